maxpool_bin_stream: RTL and testbench
=====================================

Name: maxpool_bin_stream

Overview:
- Streaming 2x2 stride-2 max-pool for binarized feature maps.
- Input pixels arrive in raster order, one per beat, with CH channel bits packed per pixel; encoding is 1 = +1, 0 = -1.
- A half-row line buffer holds the per-column partial maxima of each even row.
- One pooled pixel is emitted per completed 2x2 window over a valid/ready stream. Sits between a binary conv/sign stage and the next layer.

Parameters:
- IMG_W, 8, input row width in pixels; even, >= 2.
- IMG_H, 8, input frame height in rows; even, >= 2.
- CH, 4, channel bits per pixel.

Ports:
- clk  input  1  clock.
- n_rst  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_sof  input  1  start of frame; qualifies the accepted beat.
- in_data  input  CH  input pixel channel bits.
- out_valid  output  1  pooled pixel valid.
- out_ready  input  1  downstream accepts pooled pixel.
- out_data  output  CH  pooled pixel channel bits.
- out_last  output  1  marks the last pooled pixel of a frame.

Behaviour:
- Reset (async, n_rst=0): out_valid=0, out_data=0, out_last=0, col=0, row=0, hold=0. Line buffer contents are don't-care because they are always written before being read.
- Accept rule: accept = in_valid & in_ready. in_ready = ~out_valid | out_ready, i.e. the block stalls only when the output register is full and not draining.
- Counters: col is in 0..IMG_W-1 and row is in 0..IMG_H-1.
  - On accept, col increments. At IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_W-1, IMG_H-1), both wrap to 0.
  - Counter widths are $clog2 of the parameter, with a minimum of 1.
- Start of frame: accept with in_sof=1 forces the beat to be treated as (0,0), whatever the counter state. Counters then advance from (0,0). In-flight partial windows are discarded, and a pending output stays valid until taken.
- Even col: hold <= in_data.
- Even row, odd col: linebuf[col>>1] <= hold | in_data.
- Odd row, odd col: out_data <= linebuf[col>>1] | hold | in_data (bitwise OR per channel); out_valid <= 1.
  - out_last <= 1 when row=IMG_H-1 and col=IMG_W-1, else 0.
- Latency: out_valid rises the cycle after the accept that completes a window.
- Output register:
  - When out_valid & out_ready and no new window completes, out_valid <= 0.
  - When out_valid & out_ready coincide with a completing accept, out_valid stays 1 and the new data is loaded (full throughput).
  - out_data and out_last hold stable while out_valid & ~out_ready.
- Output rate is one pooled pixel per 4 input beats, (IMG_W/2)*(IMG_H/2) per frame.
- Line buffer: IMG_W/2 entries x CH bits. A single write (even row) or single read (odd row) per accept; reads and writes never target the same entry in the same cycle.
- Reset mid-frame: all state clears and the block waits for the next beat, which it treats as (0,0).

Optional Feature:
- Macro MAXPOOL_BIN_INV_EN, for inverted encoding (1 = -1, 0 = +1).
- Defined: every OR in the datapath becomes AND, so a pooled bit is 1 only if all four inputs are 1.
- Not defined: OR datapath as described above.
- Reset values, handshake and timing are identical in both builds.

Test Plan:
- Defaults, in_sof on the first beat, in_data=0 everywhere except pixel (row1,col1)=4'b0010 -> first pooled pixel out_data=4'b0010, the other 15 are 4'b0000; out_last=1 only on the 16th.
- Defaults, row0 pixels cycle 4'b0001, 4'b0010, 4'b0100, 4'b1000, row1 all 0 -> out_data for window 0 = 4'b0011, window 1 = 4'b1100.
- out_ready=0 for 20 cycles with in_valid=1 -> in_ready drops after the first completed window; out_data is held; no beat is lost. Then release -> all 16 outputs arrive, in order.
- in_valid and out_ready held 1 continuously -> a steady 1 output per 4 beats with no bubbles; the total count per frame is 16.
- in_sof asserted mid-frame at (3,5) -> counters restart. The next 64 beats give 16 outputs, with out_last on the 16th.
- n_rst pulse mid-row, with out_valid=1 -> out_valid=0 immediately. The following frame pools correctly. Repeat the scenario with MAXPOOL_BIN_INV_EN defined: an all-ones window except one 0 bit gives a 0 on that bit.

Source files
------------

// File: rtl/maxpool_bin_stream.sv
// Streaming 2x2 stride-2 max-pool for binarized feature maps (1 = +1, 0 = -1).
// Define MAXPOOL_BIN_INV_EN for inverted encoding: the pooling datapath then uses AND instead of OR.
module maxpool_bin_stream #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int CH    = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sof,
    input  logic [CH-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CH-1:0] out_data,
    output logic          out_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int HW = IMG_W / 2;
    localparam int LW = (HW > 1) ? $clog2(HW) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    // Max of two binarized values under the active encoding.
    function automatic logic [CH-1:0] pool2(input logic [CH-1:0] a, input logic [CH-1:0] b);
`ifdef MAXPOOL_BIN_INV_EN
        return a & b;
`else
        return a | b;
`endif
    endfunction

    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [CH-1:0] hold_r;
    logic [CH-1:0] linebuf_r [HW];
    logic          out_valid_r;
    logic [CH-1:0] out_data_r;
    logic          out_last_r;

    logic          in_ready_s;
    logic          accept_s;
    logic [CW-1:0] eff_col_s;
    logic [RW-1:0] eff_row_s;
    logic [CW-1:0] col_nxt_s;
    logic [RW-1:0] row_nxt_s;
    logic [LW-1:0] lb_idx_s;
    logic          complete_s;
    logic          last_s;

    // Handshake, effective position (sof forces (0,0)) and next counter values.
    always_comb begin
        in_ready_s = ~out_valid_r | out_ready;
        accept_s   = in_valid & in_ready_s;
        eff_col_s  = col_r;
        eff_row_s  = row_r;
        if (in_sof) begin
            eff_col_s = {CW{1'b0}};
            eff_row_s = {RW{1'b0}};
        end else begin
            eff_col_s = col_r;
            eff_row_s = row_r;
        end
        col_nxt_s = eff_col_s + CW'(1);
        row_nxt_s = eff_row_s;
        if (eff_col_s == COL_MAX) begin
            col_nxt_s = {CW{1'b0}};
            if (eff_row_s == ROW_MAX) begin
                row_nxt_s = {RW{1'b0}};
            end else begin
                row_nxt_s = eff_row_s + RW'(1);
            end
        end else begin
            row_nxt_s = eff_row_s;
        end
        lb_idx_s   = LW'(eff_col_s >> 1);
        complete_s = accept_s & eff_row_s[0] & eff_col_s[0];
        last_s     = (eff_row_s == ROW_MAX) && (eff_col_s == COL_MAX);
    end

    // Raster position counters and the even-column pixel holding register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_r  <= {CW{1'b0}};
            row_r  <= {RW{1'b0}};
            hold_r <= {CH{1'b0}};
        end else if (accept_s) begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
            if (!eff_col_s[0]) begin
                hold_r <= in_data;
            end
        end
    end

    // Half-row line buffer of even-row horizontal partial maxima; always written before read.
    always_ff @(posedge clk) begin
        if (accept_s && !eff_row_s[0] && eff_col_s[0]) begin
            linebuf_r[lb_idx_s] <= pool2(hold_r, in_data);
        end
    end

    // Output register: loads on a completed window, clears when drained with nothing new.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {CH{1'b0}};
            out_last_r  <= 1'b0;
        end else if (complete_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= pool2(linebuf_r[lb_idx_s], pool2(hold_r, in_data));
            out_last_r  <= last_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_maxpool_bin_stream.sv
// Self-checking bench for maxpool_bin_stream: table of frame scenarios plus hand-written corner sequences.
module tb_maxpool_bin_stream;

    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int CH    = 4;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_sof;
    logic [CH-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CH-1:0] out_data;
    logic          out_last;

    always #5 clk = ~clk;

    maxpool_bin_stream #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH)) dut (
        .clk(clk), .n_rst(n_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    typedef struct {
        int       pat;
        bit       stall;
        bit       chk;
        logic [3:0] w0_or;
        logic [3:0] w1_or;
        logic [3:0] w0_and;
        logic [3:0] w1_and;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic       last;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;
    int n_out = 0;
    int accepted = 0;
    int bubbles = 0;
    bit hold_chk = 1'b0;
    logic [3:0] got [0:63];
    vec_t tbl [4];

    function automatic logic [3:0] pix(input int pat, input int r, input int c);
        logic [3:0] t;
        case (pat)
            0: t = (r == 1 && c == 1) ? 4'b0010 : 4'b0000;
            1: t = (r == 0) ? (4'b0001 << (c % 4)) : 4'b0000;
            2: t = (r == 0 && c == 0) ? 4'b1110 : 4'b1111;
            default: t = 4'(((r * 13) + (c * 7) + (r * c) + pat) ^ 5);
        endcase
        return t;
    endfunction

    function automatic logic [3:0] pool4(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] c, input logic [3:0] d);
`ifdef MAXPOOL_BIN_INV_EN
        return a & b & c & d;
`else
        return a | b | c | d;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on each output handshake.
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            if (in_valid === 1'b1 && in_ready === 1'b1) accepted++;
            if (in_valid === 1'b1 && in_ready === 1'b0) bubbles++;
            if (out_valid === 1'b1) begin
                if (out_ready === 1'b1) begin
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got data %0h with empty scoreboard", out_data);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_last", 32'(out_last), 32'(e.last));
                        if (n_out < 64) got[n_out] = out_data;
                        n_out++;
                    end
                end else if (hold_chk && sbq.size() > 0) begin
                    check("stall_hold", 32'(out_data), 32'(sbq[0].data));
                end
            end
        end
    end

    task automatic send_beat(input logic [3:0] d, input logic sof);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (in_ready !== 1'b1 && t < 300);
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready stuck at %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int pat, input int nbeats, input bit first_sof);
        for (int i = 0; i < nbeats; i++) begin
            int r;
            int c;
            r = i / IMG_W;
            c = i % IMG_W;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                exp_t e;
                e.data = pool4(pix(pat, r - 1, c - 1), pix(pat, r - 1, c),
                               pix(pat, r, c - 1), pix(pat, r, c));
                e.last = (r == IMG_H - 1) && (c == IMG_W - 1);
                sbq.push_back(e);
            end
            send_beat(pix(pat, r, c), logic'(first_sof && i == 0));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() > 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", 32'(sbq.size()), 32'd0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{0, 1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        tbl[1] = '{1, 1'b0, 1'b1, 4'b0011, 4'b1100, 4'b0000, 4'b0000};
        tbl[2] = '{2, 1'b1, 1'b1, 4'b1111, 4'b1111, 4'b1110, 4'b1111};
        tbl[3] = '{3, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        n_rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 4'b0000; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 4; k++) begin
            n_out = 0;
            accepted = 0;
            bubbles = 0;
            if (tbl[k].stall) begin
                fork
                    send_frame(tbl[k].pat, 64, 1'b1);
                    begin
                        out_ready = 1'b0;
                        hold_chk = 1'b1;
                        repeat (20) @(posedge clk);
                        #1;
                        check("stall_accepted", 32'(accepted), 32'd10);
                        check("stall_in_ready", 32'(in_ready), 32'd0);
                        check("stall_out_valid", 32'(out_valid), 32'd1);
                        hold_chk = 1'b0;
                        out_ready = 1'b1;
                    end
                join
            end else begin
                send_frame(tbl[k].pat, 64, 1'b1);
                check("no_bubbles", 32'(bubbles), 32'd0);
            end
            drain();
            check("frame_out_count", 32'(n_out), 32'd16);
            if (tbl[k].chk) begin
`ifdef MAXPOOL_BIN_INV_EN
                check("win0_const", 32'(got[0]), 32'(tbl[k].w0_and));
                check("win1_const", 32'(got[1]), 32'(tbl[k].w1_and));
`else
                check("win0_const", 32'(got[0]), 32'(tbl[k].w0_or));
                check("win1_const", 32'(got[1]), 32'(tbl[k].w1_or));
`endif
            end
        end

        // Start of frame mid-frame at row 3, col 5: partial frame then a full restart.
        n_out = 0;
        send_frame(3, 3 * IMG_W + 5, 1'b1);
        send_frame(0, 64, 1'b1);
        drain();
        check("sof_mid_out_count", 32'(n_out), 32'd22);

        // Reset pulse mid-row with a pending output.
        out_ready = 1'b0;
        send_frame(2, 10, 1'b1);
        @(negedge clk);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_data", 32'(out_data), 32'd0);
        sbq.delete();
        out_ready = 1'b1;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        n_out = 0;
        send_frame(2, 64, 1'b0);
        drain();
        check("post_rst_out_count", 32'(n_out), 32'd16);
`ifdef MAXPOOL_BIN_INV_EN
        check("post_rst_win0", 32'(got[0]), 32'd14);
`else
        check("post_rst_win0", 32'(got[0]), 32'd15);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
